aes_mode_ctrl: RTL and testbench

AES_MODE_CTRL -- requirements
Module: aes_mode_ctrl

---
 rtl/aes_mode_ctrl.sv | 156 +++++++++++++++
 tb/tb_aes_mode_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_mode_ctrl.sv
// AES block-mode controller.
// Sequences ECB, CBC-encrypt and CTR messages through an external single-block
// cipher engine, one block in flight at a time. Finished blocks go into a
// first-word-fall-through output FIFO.
module aes_mode_ctrl #(
   parameter int DEPTH = 4,   // output FIFO entries, power of 2, >= 2
   parameter int CNT_W = 16   // width of the completed-block counter
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [127:0]     iv,
   input  logic [127:0]     key_in,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [127:0]     in_data,
   input  logic             in_last,
   output logic [127:0]     eng_key,
   output logic [127:0]     eng_text,
   output logic             eng_en,
   input  logic [127:0]     eng_result,
   input  logic             eng_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [127:0]     out_data,
   output logic             out_last,
   output logic             busy,
   output logic [CNT_W-1:0] blk_cnt,
   output logic             mode_err
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FCNT_W = PTR_W + 1;

   typedef enum logic [1:0] {IDLE, WAIT_IN, ISSUE, ENG_RUN} state_t;
   typedef enum logic [1:0] {
      MODE_ECB = 2'b00,
      MODE_CBC = 2'b01,
      MODE_CTR = 2'b10,
      MODE_RSV = 2'b11
   } mode_t;

   state_t             state;
   mode_t              mode_q;
   logic [127:0]       chain;      // CBC chaining value or CTR counter block
   logic [127:0]       data_q;     // plaintext of the block in flight
   logic               last_q;
   logic [127:0]       text_sel;
   logic [127:0]       push_data;
   logic               push;
   logic               pop;

   logic [128:0]       fifo_mem [DEPTH];  // {ciphertext, last}
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [FCNT_W-1:0]  count;

   // A block is only accepted while a FIFO slot is free; since only one block
   // is ever in flight, that slot is still free when the engine finishes.
   assign in_ready  = (state == WAIT_IN) && (count < FCNT_W'(DEPTH));
   assign busy      = (state != IDLE);
   assign push      = (state == ENG_RUN) && eng_ready;
   assign pop       = out_valid && out_ready;
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? fifo_mem[rd_ptr][128:1] : '0;
   assign out_last  = out_valid & fifo_mem[rd_ptr][0];
   assign push_data = (mode_q == MODE_CTR) ? (eng_result ^ data_q) : eng_result;

   // Engine input block for the plaintext being accepted this cycle.
   always_comb begin
      // NOTE: default assignment first so no path leaves text_sel unassigned (no latch).
      text_sel = in_data;
      case (mode_q)
         MODE_CBC: text_sel = in_data ^ chain;
         MODE_CTR: text_sel = chain;
         default:  text_sel = in_data;   // ECB and reserved mode
      endcase
   end

   // Message sequencer: latches message context, issues blocks, chains results.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         mode_q   <= MODE_ECB;
         chain    <= '0;
         data_q   <= '0;
         last_q   <= 1'b0;
         eng_key  <= '0;
         eng_text <= '0;
         eng_en   <= 1'b0;
         blk_cnt  <= '0;
         mode_err <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         eng_en <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_q  <= mode_t'(mode);
                  chain   <= iv;
                  eng_key <= key_in;
                  blk_cnt <= '0;
                  if (mode_t'(mode) == MODE_RSV) mode_err <= 1'b1;
                  state   <= WAIT_IN;
               end
            end
            WAIT_IN: begin
               if (in_valid && in_ready) begin
                  data_q   <= in_data;
                  last_q   <= in_last;
                  eng_text <= text_sel;
                  eng_en   <= 1'b1;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               state <= ENG_RUN;
            end
            ENG_RUN: begin
               if (eng_ready) begin
                  blk_cnt <= blk_cnt + CNT_W'(1);
                  if (mode_q == MODE_CBC) chain <= eng_result;
                  if (mode_q == MODE_CTR) chain[31:0] <= chain[31:0] + 32'd1;
                  state <= last_q ? IDLE : WAIT_IN;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // FIFO storage write port.
   always_ff @(posedge clk_sys) begin
      // NOTE: storage array is not reset; out_valid gates every read of it.
      if (push) fifo_mem[wr_ptr] <= {push_data, last_q};
   end

   // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + FCNT_W'(1);
            2'b01:   count <= count - FCNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl with an AES-128 engine model of latency L.
module tb_aes_mode_ctrl;

   localparam int L     = 11;
   localparam int DEPTH = 4;
   localparam int CNT_W = 16;

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   logic             clk_sys, rst_n, start;
   logic [1:0]       mode;
   logic [127:0]     iv, key_in, in_data, eng_key, eng_text, eng_result, out_data;
   logic             in_valid, in_ready, in_last, eng_en, eng_ready;
   logic             out_valid, out_ready, out_last, busy, mode_err;
   logic [CNT_W-1:0] blk_cnt;

   int n_pass  = 0;
   int n_total = 0;
   int eng_cnt = 0;

   logic [127:0] outq_d [$];
   logic         outq_l [$];
   logic [127:0] txtq   [$];
   logic [7:0]   sbox_t [256];

   aes_mode_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .start(start), .mode(mode), .iv(iv),
      .key_in(key_in), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .eng_key(eng_key), .eng_text(eng_text), .eng_en(eng_en),
      .eng_result(eng_result), .eng_ready(eng_ready), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
      .blk_cnt(blk_cnt), .mode_err(mode_err)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   // ---------------- AES-128 reference model ----------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
      return (x << k) | (x >> (8 - k));
   endfunction

   task automatic init_sbox();
      logic [7:0] inv;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         if (v != 0) begin
            inv = 8'h01;
            for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(v));
         end
         sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
      logic [31:0]  w [44];
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [127:0] st;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                  ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      st = pt ^ {w[0], w[1], w[2], w[3]};
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) b[i] = sbox_t[st[127-8*i -: 8]];
         for (int rw = 0; rw < 4; rw++)
            for (int c = 0; c < 4; c++) t[rw+4*c] = b[rw+4*((c+rw)%4)];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               b[4*c]   = xtime(t[4*c]) ^ xtime(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
               b[4*c+1] = t[4*c] ^ xtime(t[4*c+1]) ^ xtime(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
               b[4*c+2] = t[4*c] ^ t[4*c+1] ^ xtime(t[4*c+2]) ^ xtime(t[4*c+3]) ^ t[4*c+3];
               b[4*c+3] = xtime(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xtime(t[4*c+3]);
            end
         end else begin
            for (int i = 0; i < 16; i++) b[i] = t[i];
         end
         for (int i = 0; i < 16; i++) st[127-8*i -: 8] = b[i];
         st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
      return st;
   endfunction

   // ---------------- engine model and output monitor ----------------
   initial begin
      logic [127:0] k, t;
      eng_ready  = 1'b0;
      eng_result = '0;
      forever begin
         @(negedge clk_sys);
         if (eng_en === 1'b1) begin
            k = eng_key;
            t = eng_text;
            txtq.push_back(t);
            eng_cnt++;
            repeat (L) @(negedge clk_sys);
            eng_result = aes_enc(k, t);
            eng_ready  = 1'b1;
            @(negedge clk_sys);
            eng_ready  = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk_sys);
         #1;
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            outq_d.push_back(out_data);
            outq_l.push_back(out_last);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_msg(input logic [1:0] m, input logic [127:0] v, input logic [127:0] k);
      @(negedge clk_sys);
      start = 1'b1; mode = m; iv = v; key_in = k;
      @(negedge clk_sys);
      start = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] d, input logic l);
      int c;
      c = 0;
      in_valid = 1'b1; in_data = d; in_last = l;
      while (in_ready !== 1'b1 && c < 200) begin
         @(negedge clk_sys);
         c++;
      end
      if (in_ready !== 1'b1) begin
         n_total++;
         $display("FAIL send_block timeout: in_ready got %b, required 1", in_ready);
         in_valid = 1'b0;
      end else begin
         @(negedge clk_sys);
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_outs(input int n);
      int c;
      c = 0;
      while (outq_d.size() < n && c < 300) begin
         @(negedge clk_sys);
         c++;
      end
      @(negedge clk_sys);
      n_total++;
      if (outq_d.size() != n) $display("FAIL out_count: got %0d blocks, required %0d", outq_d.size(), n);
      else n_pass++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk_sys);
      n_total++; if (in_ready  !== 1'b0) $display("FAIL rst_in_ready: got %b, required 0", in_ready);   else n_pass++;
      n_total++; if (eng_en    !== 1'b0) $display("FAIL rst_eng_en: got %b, required 0", eng_en);       else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", out_valid); else n_pass++;
      n_total++; if (out_last  !== 1'b0) $display("FAIL rst_out_last: got %b, required 0", out_last);   else n_pass++;
      n_total++; if (busy      !== 1'b0) $display("FAIL rst_busy: got %b, required 0", busy);           else n_pass++;
      n_total++; if (mode_err  !== 1'b0) $display("FAIL rst_mode_err: got %b, required 0", mode_err);   else n_pass++;
      n_total++; if (blk_cnt   !== '0)   $display("FAIL rst_blk_cnt: got %0d, required 0", blk_cnt);    else n_pass++;
      n_total++; if (out_data  !== '0)   $display("FAIL rst_out_data: got %h, required 0", out_data);   else n_pass++;
      n_total++; if (eng_text  !== '0)   $display("FAIL rst_eng_text: got %h, required 0", eng_text);   else n_pass++;
      n_total++; if (eng_key   !== '0)   $display("FAIL rst_eng_key: got %h, required 0", eng_key);     else n_pass++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk_sys);
      n_total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b, required 0", busy); else n_pass++;
   endtask

   task automatic test_ecb_fips();
      int c;
      outq_d.delete(); outq_l.delete();
      out_ready = 1'b0;
      start_msg(2'b00, '0, FIPS_KEY);
      send_block(FIPS_PT, 1'b1);
      n_total++; if (eng_en   !== 1'b1)     $display("FAIL ecb_eng_en: got %b, required 1", eng_en);       else n_pass++;
      n_total++; if (eng_text !== FIPS_PT)  $display("FAIL ecb_eng_text: got %h, required %h", eng_text, FIPS_PT); else n_pass++;
      n_total++; if (eng_key  !== FIPS_KEY) $display("FAIL ecb_eng_key: got %h, required %h", eng_key, FIPS_KEY);  else n_pass++;
      c = 0;
      do begin
         @(negedge clk_sys);
         c++;
      end while (out_valid !== 1'b1 && c < 50);
      n_total++; if (c != L + 1) $display("FAIL ecb_latency: got %0d cycles, required %0d", c, L + 1); else n_pass++;
      n_total++; if (out_data !== FIPS_CT) $display("FAIL ecb_out_data: got %h, required %h", out_data, FIPS_CT); else n_pass++;
      n_total++; if (out_last !== 1'b1) $display("FAIL ecb_out_last: got %b, required 1", out_last); else n_pass++;
      n_total++; if (blk_cnt  !== 16'd1) $display("FAIL ecb_blk_cnt: got %0d, required 1", blk_cnt); else n_pass++;
      n_total++; if (busy     !== 1'b0) $display("FAIL ecb_busy: got %b, required 0", busy); else n_pass++;
      out_ready = 1'b1;
      repeat (2) @(negedge clk_sys);
      n_total++; if (out_valid !== 1'b0) $display("FAIL ecb_drained: got %b, required 0", out_valid); else n_pass++;
   endtask

   task automatic test_cbc();
      logic [127:0] t2;
      outq_d.delete(); outq_l.delete(); txtq.delete();
      out_ready = 1'b1;
      t2 = FIPS_PT ^ FIPS_CT;
      start_msg(2'b01, '0, FIPS_KEY);
      send_block(FIPS_PT, 1'b0);
      send_block(FIPS_PT, 1'b1);
      wait_outs(2);
      n_total++; if (txtq.size() != 2) $display("FAIL cbc_issues: got %0d, required 2", txtq.size()); else n_pass++;
      n_total++; if (txtq[1]   !== t2)      $display("FAIL cbc_text2: got %h, required %h", txtq[1], t2); else n_pass++;
      n_total++; if (outq_d[0] !== FIPS_CT) $display("FAIL cbc_blk1: got %h, required %h", outq_d[0], FIPS_CT); else n_pass++;
      n_total++; if (outq_d[1] !== aes_enc(FIPS_KEY, t2)) $display("FAIL cbc_blk2: got %h, required %h", outq_d[1], aes_enc(FIPS_KEY, t2)); else n_pass++;
      n_total++; if (outq_l[0] !== 1'b0 || outq_l[1] !== 1'b1) $display("FAIL cbc_last: got %b%b, required 01", outq_l[0], outq_l[1]); else n_pass++;
      n_total++; if (blk_cnt !== 16'd2) $display("FAIL cbc_blk_cnt: got %0d, required 2", blk_cnt); else n_pass++;
   endtask

   task automatic test_ctr();
      logic [127:0] ctr0, ctr1, p1, p2;
      ctr0 = 128'hf0f1f2f3_f4f5f6f7_f8f9fafb_ffffffff;
      ctr1 = 128'hf0f1f2f3_f4f5f6f7_f8f9fafb_00000000;
      p1   = 128'h6bc1bee2_2e409f96_e93d7e11_7393172a;
      p2   = 128'hae2d8a57_1e03ac9c_9eb76fac_45af8e51;
      outq_d.delete(); outq_l.delete(); txtq.delete();
      start_msg(2'b10, ctr0, FIPS_KEY);
      send_block(p1, 1'b0);
      send_block(p2, 1'b1);
      wait_outs(2);
      n_total++; if (txtq[0] !== ctr0) $display("FAIL ctr_text1: got %h, required %h", txtq[0], ctr0); else n_pass++;
      n_total++; if (txtq[1] !== ctr1) $display("FAIL ctr_text2: got %h, required %h", txtq[1], ctr1); else n_pass++;
      n_total++; if (outq_d[0] !== (aes_enc(FIPS_KEY, ctr0) ^ p1)) $display("FAIL ctr_blk1: got %h, required %h", outq_d[0], aes_enc(FIPS_KEY, ctr0) ^ p1); else n_pass++;
      n_total++; if (outq_d[1] !== (aes_enc(FIPS_KEY, ctr1) ^ p2)) $display("FAIL ctr_blk2: got %h, required %h", outq_d[1], aes_enc(FIPS_KEY, ctr1) ^ p2); else n_pass++;
   endtask

   task automatic test_backpressure();
      logic [127:0] d [6];
      int base;
      logic rdy_seen;
      for (int i = 0; i < 6; i++) d[i] = {32'hc0de0000 + 32'(i), 32'h12345678, 32'(i * 7), 32'hdeadbeef};
      outq_d.delete(); outq_l.delete();
      out_ready = 1'b0;
      base = eng_cnt;
      start_msg(2'b00, '0, FIPS_KEY);
      for (int i = 0; i < 4; i++) send_block(d[i], 1'b0);
      rdy_seen = 1'b0;
      in_valid = 1'b1; in_data = d[4]; in_last = 1'b0;
      repeat (30) begin
         @(negedge clk_sys);
         if (in_ready === 1'b1) rdy_seen = 1'b1;
      end
      n_total++; if (rdy_seen !== 1'b0) $display("FAIL bp_in_ready: got 1, required 0 while full"); else n_pass++;
      n_total++; if (eng_cnt != base + 4) $display("FAIL bp_eng_en: got %0d pulses, required %0d", eng_cnt - base, 4); else n_pass++;
      n_total++; if (blk_cnt !== 16'd4) $display("FAIL bp_blk_cnt: got %0d, required 4", blk_cnt); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b, required 1", out_valid); else n_pass++;
      out_ready = 1'b1;
      send_block(d[4], 1'b0);
      send_block(d[5], 1'b1);
      wait_outs(6);
      for (int i = 0; i < 6; i++) begin
         n_total++;
         if (outq_d[i] !== aes_enc(FIPS_KEY, d[i]))
            $display("FAIL bp_data%0d: got %h, required %h", i, outq_d[i], aes_enc(FIPS_KEY, d[i]));
         else n_pass++;
         n_total++;
         if (outq_l[i] !== (i == 5))
            $display("FAIL bp_last%0d: got %b, required %b", i, outq_l[i], (i == 5));
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [127:0] p2;
      p2 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      outq_d.delete(); outq_l.delete();
      out_ready = 1'b0;
      start_msg(2'b00, '0, FIPS_KEY);
      send_block(FIPS_PT, 1'b1);
      repeat (L + 3) @(negedge clk_sys);
      start_msg(2'b00, '0, FIPS_KEY);
      send_block(p2, 1'b1);
      repeat (L + 3) @(negedge clk_sys);
      n_total++; if (blk_cnt !== 16'd1) $display("FAIL b2b_blk_cnt: got %0d, required 1", blk_cnt); else n_pass++;
      out_ready = 1'b1;
      wait_outs(2);
      n_total++; if (outq_d[0] !== FIPS_CT) $display("FAIL b2b_blk1: got %h, required %h", outq_d[0], FIPS_CT); else n_pass++;
      n_total++; if (outq_d[1] !== aes_enc(FIPS_KEY, p2)) $display("FAIL b2b_blk2: got %h, required %h", outq_d[1], aes_enc(FIPS_KEY, p2)); else n_pass++;
      n_total++; if (outq_l[0] !== 1'b1 || outq_l[1] !== 1'b1) $display("FAIL b2b_last: got %b%b, required 11", outq_l[0], outq_l[1]); else n_pass++;
   endtask

   task automatic test_mode_err();
      logic [127:0] k2, p1, p2;
      int c;
      k2 = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
      p1 = 128'h11111111_22222222_33333333_44444444;
      p2 = 128'h55555555_66666666_77777777_88888888;
      outq_d.delete(); outq_l.delete();
      out_ready = 1'b1;
      start_msg(2'b11, '0, k2);
      send_block(p1, 1'b0);
      c = 0;
      while (in_ready !== 1'b1 && c < 50) begin
         @(negedge clk_sys);
         c++;
      end
      start_msg(2'b01, {128{1'b1}}, {128{1'b1}});
      n_total++; if (busy !== 1'b1) $display("FAIL me_busy: got %b, required 1", busy); else n_pass++;
      n_total++; if (eng_key !== k2) $display("FAIL me_key_kept: got %h, required %h", eng_key, k2); else n_pass++;
      send_block(p2, 1'b1);
      wait_outs(2);
      n_total++; if (mode_err !== 1'b1) $display("FAIL me_flag: got %b, required 1", mode_err); else n_pass++;
      n_total++; if (outq_d[0] !== aes_enc(k2, p1)) $display("FAIL me_blk1: got %h, required %h", outq_d[0], aes_enc(k2, p1)); else n_pass++;
      n_total++; if (outq_d[1] !== aes_enc(k2, p2)) $display("FAIL me_blk2: got %h, required %h", outq_d[1], aes_enc(k2, p2)); else n_pass++;
   endtask

   task automatic test_reset_midflight();
      int c;
      outq_d.delete(); outq_l.delete();
      out_ready = 1'b1;
      start_msg(2'b00, '0, FIPS_KEY);
      n_total++; if (mode_err !== 1'b1) $display("FAIL rm_sticky: got %b, required 1", mode_err); else n_pass++;
      send_block(FIPS_PT, 1'b0);
      repeat (3) @(negedge clk_sys);
      rst_n = 1'b0;
      #1;
      n_total++; if (busy !== 1'b0) $display("FAIL rm_async_busy: got %b, required 0", busy); else n_pass++;
      @(negedge clk_sys);
      rst_n = 1'b1;
      c = 0;
      while (eng_ready !== 1'b1 && c < 40) begin
         @(negedge clk_sys);
         c++;
      end
      n_total++; if (eng_ready !== 1'b1) $display("FAIL rm_late_ready: got %b, required 1", eng_ready); else n_pass++;
      repeat (3) @(negedge clk_sys);
      n_total++; if (out_valid !== 1'b0) $display("FAIL rm_out_valid: got %b, required 0", out_valid); else n_pass++;
      n_total++; if (outq_d.size() != 0) $display("FAIL rm_outputs: got %0d blocks, required 0", outq_d.size()); else n_pass++;
      n_total++; if (blk_cnt   !== '0)   $display("FAIL rm_blk_cnt: got %0d, required 0", blk_cnt); else n_pass++;
      n_total++; if (busy      !== 1'b0) $display("FAIL rm_busy: got %b, required 0", busy); else n_pass++;
      n_total++; if (in_ready  !== 1'b0) $display("FAIL rm_in_ready: got %b, required 0", in_ready); else n_pass++;
      n_total++; if (mode_err  !== 1'b0) $display("FAIL rm_mode_err: got %b, required 0", mode_err); else n_pass++;
      n_total++; if (eng_text  !== '0)   $display("FAIL rm_eng_text: got %h, required 0", eng_text); else n_pass++;
      n_total++; if (eng_key   !== '0)   $display("FAIL rm_eng_key: got %h, required 0", eng_key); else n_pass++;
      n_total++; if (out_data  !== '0)   $display("FAIL rm_out_data: got %h, required 0", out_data); else n_pass++;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 2'b00; iv = '0; key_in = '0;
      in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
      init_sbox();
      test_reset();
      test_ecb_fips();
      test_cbc();
      test_ctr();
      test_backpressure();
      test_back_to_back();
      test_mode_err();
      test_reset_midflight();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
